// File: rtl/f2h_arb_pkg.sv
// rtl/f2h_arb_pkg.sv - shared types and constants for the host-bound burst arbiter
package f2h_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } arbState;

    // Upper five bits of every header byte; the low three carry the source id
    localparam logic [4:0] HDR_TAG = 5'b10000;
    localparam int CNT_W = 8;
    localparam int ID_W  = 3;

    function automatic logic [7:0] mkHeader(input logic [ID_W-1:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/f2h_burst_arbiter_rr_picker.sv
// rtl/f2h_burst_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker
    import f2h_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    index
);

    logic              hiAny;
    logic [ID_W-1:0]   hiIdx;
    logic [ID_W-1:0]   loIdx;

    // Lowest requester above last wins; if none, wrap to the lowest requester overall
    always_comb begin
        hiAny = 1'b0;
        hiIdx = '0;
        loIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                loIdx = ID_W'(i);
                if (ID_W'(i) > last) begin
                    hiAny = 1'b1;
                    hiIdx = ID_W'(i);
                end
            end
        end
        any   = |req;
        index = hiAny ? hiIdx : loIdx;
    end

endmodule

// File: rtl/f2h_burst_arbiter.sv
// rtl/f2h_burst_arbiter.sv - round-robin burst scheduler for the FPGA-to-host byte pipe
module f2h_burst_arbiter
    import f2h_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [8*NUM_REQ-1:0] reqData_in,
    input  logic [NUM_REQ-1:0]   reqValid_in,
    output logic [NUM_REQ-1:0]   reqReady_out,
    output logic [7:0]           outData_out,
    output logic                 outValid_out,
    input  logic                 outReady_in,
    output logic [2:0]           grant_out,
    output logic                 busy_out
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    arbState          state;
    arbState          nextState;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  nextGrant;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  nextLast;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] nextCount;

    logic             pickAny;
    logic [ID_W-1:0]  pickIdx;

    // Requester lanes padded to eight so the 3-bit grant indexes them directly
    logic [7:0] reqBytes [8];
    logic [7:0] validPad;
    logic [7:0] curData;
    logic       curValid;

    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_real
            assign reqBytes[g] = reqData_in[8*g +: 8];
        end else begin : g_zero
            assign reqBytes[g] = 8'h00;
        end
    end

    assign validPad = 8'(reqValid_in);
    assign curData  = reqBytes[grant];
    assign curValid = validPad[grant];

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) uPicker (
        .req   (reqValid_in),
        .last  (last),
        .any   (pickAny),
        .index (pickIdx)
    );

    // State, grant, round-robin pointer and burst counter registers
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state <= S_IDLE;
            grant <= '0;
            last  <= ID_W'(NUM_REQ - 1);
            count <= '0;
        end else begin
            state <= nextState;
            grant <= nextGrant;
            last  <= nextLast;
            count <= nextCount;
        end
    end

    // Next-state and output decode; data-phase handshakes pass straight through
    always_comb begin
        nextState    = state;
        nextGrant    = grant;
        nextLast     = last;
        nextCount    = count;
        outValid_out = 1'b0;
        outData_out  = 8'h00;
        reqReady_out = '0;
        case (state)
            S_IDLE: begin
                if (pickAny) begin
                    nextGrant = pickIdx;
                    nextState = S_HDR;
                end
            end
            S_HDR: begin
                outValid_out = 1'b1;
                outData_out  = mkHeader(grant);
                if (outReady_in) begin
                    nextCount = '0;
                    nextState = S_DATA;
                end
            end
            S_DATA: begin
                outValid_out = curValid;
                outData_out  = curData;
                for (int i = 0; i < NUM_REQ; i++) begin
                    reqReady_out[i] = outReady_in && (grant == ID_W'(i));
                end
                if (!curValid) begin
                    nextLast  = grant;
                    nextState = S_IDLE;
                end else if (outReady_in) begin
                    nextCount = count + 1'b1;
                    if (nextCount == BURST_LIM) begin
                        nextLast  = grant;
                        nextState = S_IDLE;
                    end
                end
            end
            default: begin
                nextState = S_IDLE;
            end
        endcase
    end

    assign grant_out = grant;
    assign busy_out  = (state != S_IDLE);

endmodule

// File: tb/tb_f2h_burst_arbiter.sv
// tb/tb_f2h_burst_arbiter.sv - directed self-checking bench for f2h_burst_arbiter
module tb_f2h_burst_arbiter;

    localparam int NR = 4;
    localparam int MB = 16;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [8*NR-1:0] reqData_in;
    logic [NR-1:0]   reqValid_in;
    logic [NR-1:0]   reqReady_out;
    logic [7:0]      outData_out;
    logic            outValid_out;
    logic            outReady_in;
    logic [2:0]      grant_out;
    logic            busy_out;

    always #5 clk_in = ~clk_in;

    f2h_burst_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .reqData_in   (reqData_in),
        .reqValid_in  (reqValid_in),
        .reqReady_out (reqReady_out),
        .outData_out  (outData_out),
        .outValid_out (outValid_out),
        .outReady_in  (outReady_in),
        .grant_out    (grant_out),
        .busy_out     (busy_out)
    );

    int         nAssert = 0;
    int         nFail   = 0;
    int         cyc     = 0;
    int         ptr  [NR];
    int         lim  [NR];
    int         base [NR];
    bit         en   [NR];
    bit         fire [NR];
    bit         toggleReady;
    logic [7:0] capQ [$];
    int         capCyc [$];
    logic [7:0] expQ [$];
    logic [NR-1:0] otherRdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] capAt(input int k);
        if (k < capQ.size()) return capQ[k];
        return 8'hxx;
    endfunction

    function automatic int cycAt(input int k);
        if (k < capCyc.size()) return capCyc[k];
        return -1000;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            reqValid_in[i]        = en[i] && (ptr[i] < lim[i]);
            reqData_in[8*i +: 8]  = 8'(base[i] + ptr[i]);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        for (int i = 0; i < NR; i++) fire[i] = reset_in && reqValid_in[i] && reqReady_out[i];
        if (reset_in && outValid_out && outReady_in) begin
            capQ.push_back(outData_out);
            capCyc.push_back(cyc);
        end
        @(posedge clk_in);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (fire[i]) ptr[i]++;
        if (toggleReady) outReady_in = ~outReady_in;
        drive();
        #1;
    endtask

    task automatic restart();
        reset_in    = 1'b0;
        toggleReady = 1'b0;
        outReady_in = 1'b1;
        for (int i = 0; i < NR; i++) ptr[i] = 0;
        drive();
        tick();
        tick();
        reset_in = 1'b1;
        capQ.delete();
        capCyc.delete();
        expQ.delete();
    endtask

    task automatic checkStream(input string tag);
        chk({tag, "_len"}, capQ.size(), expQ.size());
        for (int k = 0; k < expQ.size(); k++) chk($sformatf("%s_b%0d", tag, k), capAt(k), expQ[k]);
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_valid"}, outValid_out, 1'b0);
        chk({tag, "_data"},  outData_out,  8'h00);
        chk({tag, "_ready"}, reqReady_out, 4'h0);
        chk({tag, "_grant"}, grant_out,    3'd0);
        chk({tag, "_busy"},  busy_out,     1'b0);
    endtask

    initial begin
        // Reset held three cycles with everyone requesting
        for (int i = 0; i < NR; i++) begin
            en[i] = 1'b1; lim[i] = 255; base[i] = i * 64; ptr[i] = 0;
        end
        reset_in    = 1'b0;
        outReady_in = 1'b1;
        toggleReady = 1'b0;
        drive();
        for (int t = 0; t < 3; t++) begin
            tick();
            checkIdleOutputs($sformatf("rst%0d", t));
        end
        reset_in = 1'b1;
        tick();
        chk("rst_hdr_valid", outValid_out, 1'b1);
        chk("rst_hdr_data",  outData_out,  8'h80);
        chk("rst_hdr_grant", grant_out,    3'd0);
        chk("rst_hdr_busy",  busy_out,     1'b1);
        chk("rst_hdr_ready", reqReady_out, 4'h0);
        tick();
        chk("rst_d0_ready", reqReady_out, 4'b0001);
        chk("rst_d0_data",  outData_out,  8'h00);
        chk("rst_d0_valid", outValid_out, 1'b1);

        // Single stream on requester 2, 40 bytes
        for (int i = 0; i < NR; i++) en[i] = 1'b0;
        en[2] = 1'b1; base[2] = 0; lim[2] = 40;
        restart();
        repeat (60) tick();
        expQ.push_back(8'h82);
        for (int j = 0; j < 16; j++) expQ.push_back(8'(j));
        expQ.push_back(8'h82);
        for (int j = 16; j < 32; j++) expQ.push_back(8'(j));
        expQ.push_back(8'h82);
        for (int j = 32; j < 40; j++) expQ.push_back(8'(j));
        checkStream("single");
        chk("single_gap1", cycAt(17) - cycAt(16), 2);
        chk("single_gap2", cycAt(34) - cycAt(33), 2);
        chk("single_end_busy", busy_out, 1'b0);

        // Round-robin over all four requesters
        for (int i = 0; i < NR; i++) begin
            en[i] = 1'b1; lim[i] = 255; base[i] = i * 64;
        end
        restart();
        repeat (80) tick();
        for (int k = 0; k < 4; k++) begin
            expQ.push_back(8'(8'h80 + k));
            for (int j = 0; j < 16; j++) expQ.push_back(8'(k * 64 + j));
        end
        expQ.push_back(8'h80);
        chk("rr_len_min", capQ.size() >= expQ.size(), 1'b1);
        for (int k = 0; k < expQ.size(); k++) chk($sformatf("rr_b%0d", k), capAt(k), expQ[k]);

        // Backpressure: outReady_in toggles every cycle
        for (int i = 0; i < NR; i++) en[i] = 1'b0;
        en[0] = 1'b1; lim[0] = 20; base[0] = 0;
        en[1] = 1'b1; lim[1] = 20; base[1] = 64;
        restart();
        toggleReady = 1'b1;
        for (int t = 0; t < 160; t++) begin
            tick();
            otherRdy = reqReady_out & ~(4'b0001 << grant_out[1:0]);
            chk("bp_other_ready", otherRdy, 4'h0);
            if (outValid_out && !outData_out[7])
                chk("bp_data_ready", reqReady_out[grant_out[1:0]], outReady_in);
            if (outValid_out && outData_out[7])
                chk("bp_hdr_ready", reqReady_out, 4'h0);
        end
        toggleReady = 1'b0;
        outReady_in = 1'b1;
        expQ.push_back(8'h80);
        for (int j = 0; j < 16; j++) expQ.push_back(8'(j));
        expQ.push_back(8'h81);
        for (int j = 0; j < 16; j++) expQ.push_back(8'(64 + j));
        expQ.push_back(8'h80);
        for (int j = 16; j < 20; j++) expQ.push_back(8'(j));
        expQ.push_back(8'h81);
        for (int j = 16; j < 20; j++) expQ.push_back(8'(64 + j));
        checkStream("bp");

        // Early end: requester 1 sends three bytes, requester 2 follows
        for (int i = 0; i < NR; i++) en[i] = 1'b0;
        en[1] = 1'b1; lim[1] = 3; base[1] = 64;
        en[2] = 1'b1; lim[2] = 2; base[2] = 128;
        restart();
        repeat (30) tick();
        expQ = '{8'h81, 8'h40, 8'h41, 8'h42, 8'h82, 8'h80, 8'h81};
        checkStream("early");
        chk("early_gap", cycAt(4) - cycAt(3), 3);
        chk("early_end_busy", busy_out, 1'b0);

        // Reset in the middle of a burst from requester 3
        for (int i = 0; i < NR; i++) en[i] = 1'b0;
        en[3] = 1'b1; lim[3] = 255; base[3] = 192;
        restart();
        for (int t = 0; t < 20 && capQ.size() < 6; t++) tick();
        chk("mr_count", capQ.size(), 6);
        chk("mr_hdr", capAt(0), 8'h83);
        chk("mr_b4",  capAt(5), 8'hC4);
        chk("mr_pre_valid", outValid_out, 1'b1);
        for (int i = 0; i < NR; i++) begin
            en[i] = 1'b1; base[i] = i * 64;
        end
        reset_in = 1'b0;
        drive();
        tick();
        checkIdleOutputs("mr_rst");
        reset_in = 1'b1;
        tick();
        chk("mr_after_valid", outValid_out, 1'b1);
        chk("mr_after_hdr",   outData_out,  8'h80);
        chk("mr_after_grant", grant_out,    3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/f2h_burst_arbiter.md
# f2h_burst_arbiter

Round-robin scheduler that shares the host-bound (FPGA-to-host) byte pipe between up to eight producer streams, such as counters, FIFO depth monitors and peripheral samplers. It grants one requester at a time, emits a one-byte header identifying the source, then forwards a bounded burst of that source's bytes. It sits between the producers and the input of the read FIFO that feeds channel 0 of the comm interface.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `MAX_BURST`, default 16: maximum data bytes per grant; legal range 1..255.
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `reset_in`  input  1  reset, synchronous and active-low.
- `reqData_in`  input  8*NUM_REQ  requester data; requester i occupies bits [8i+7:8i].
- `reqValid_in`  input  NUM_REQ  per-requester valid.
- `reqReady_out`  output  NUM_REQ  per-requester ready; at most one bit high.
- `outData_out`  output  8  byte to the read FIFO.
- `outValid_out`  output  1  outData_out is valid.
- `outReady_in`  input  1  read FIFO can accept a byte.
- `grant_out`  output  3  index of the current or last granted requester.
- `busy_out`  output  1  high in S_HDR and S_DATA.

## Operation
- A transfer occurs on any edge where valid and ready are both high. Data must be held stable while valid is high and ready is low.
- States:
  - **S_IDLE**
    - If any reqValid_in is high, pick the first valid index searching upward (modulo NUM_REQ) from `last+1`.
    - Register that index as `grant` and go to S_HDR.
    - Otherwise stay in S_IDLE.
  - **S_HDR**
    - Drive outValid_out=1 and outData_out={1'b1, 4'b0000, grant[2:0]}.
    - On outReady_in, clear the burst counter and go to S_DATA.
  - **S_DATA**
    - outData_out = reqData_in[grant], outValid_out = reqValid_in[grant], reqReady_out[grant] = outReady_in.
    - Each transfer increments the 8-bit counter.
    - If the transfer makes the count equal MAX_BURST, set `last <= grant` and go to S_IDLE.
    - If reqValid_in[grant] is low at an edge, end the burst: set `last <= grant` and go to S_IDLE. A burst of zero data bytes is legal.
- Outside S_DATA, all reqReady_out bits are 0.
- Fairness: a requester that is continuously valid is granted within NUM_REQ-1 intervening bursts.
- Out-of-range requesters: if NUM_REQ<8, indices ≥ NUM_REQ are never granted.
- Reset, including mid-burst:
  - state=S_IDLE, last=NUM_REQ-1 (so requester 0 has first priority), counter=0, grant=0.
  - All outputs 0.
  - A partially sent burst is abandoned with no trailer.

## Timing
- Every output is 0 during and immediately after reset.
- Arbitration costs exactly one cycle in S_IDLE. The header is presented on the edge after grant.
- Minimum cost per burst of N bytes with outReady_in held high: 1 (idle) + 1 (header) + N cycles.
- A burst ended by valid dropping costs one extra S_DATA cycle.
- In S_DATA, outValid_out and reqReady_out are combinational from inputs: no added latency and no skid buffer.
- The header is held with outValid_out=1 until it is accepted. Backpressure on outReady_in stalls all states except S_IDLE.
- Simultaneous events:
  - Count reaching MAX_BURST together with valid dropping: the burst ends once, in S_IDLE.
  - A new request arriving during S_HDR or S_DATA is considered at the next S_IDLE.
- MAX_BURST=255: the counter never wraps. Termination is by compare, not overflow.

## Structure
- Shared package `f2h_arb_pkg`:
  - State typedef {S_IDLE, S_HDR, S_DATA}.
  - Header marker constant HDR_TAG=5'b10000.
  - Counter width 8 and ID width 3.
- Sub-module `rr_picker`: combinational round-robin priority encoder.
  - Inputs: request vector and `last`.
  - Outputs: `any`, `index`.
  - Instantiated once.
- Expected size: about 200 lines of RTL.

## Test plan
- **Reset**: hold reset_in=0 for 3 cycles with all reqValid_in=1.
  - All outputs stay 0.
  - After release, the first header is 8'h80, granting requester 0.
- **Single stream**: requester 2 is always valid with data 0..39, outReady_in=1, MAX_BURST=16.
  - Output is 82, 0..15, 82, 16..31, 82, 32..39 and onward.
  - Each gap between a burst's last byte and the next header is 1 idle cycle.
- **Round-robin**: all four requesters always valid.
  - Headers appear in order 80, 81, 82, 83, 80.
  - Each header is followed by exactly 16 bytes from that requester.
- **Backpressure**: toggle outReady_in every cycle mid-header and mid-data.
  - No byte is lost or duplicated.
  - reqReady_out[grant] equals outReady_in exactly.
- **Early end**: requester 1 sends 3 bytes, then drops valid.
  - Output is 81 followed by those 3 bytes.
  - The arbiter then returns to S_IDLE and grants the next valid requester above 1.
- **Reset mid-burst**: assert reset after 5 of 16 bytes from requester 3.
  - Outputs clear on the next edge.
  - After release, the first header is 80, not 83.
